// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// default operand width and the counter sizing rule.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must index 0..WIDTH-1 and is never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for serial_add_ctrl.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, abort, a, b, cin,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, abort, a, b, cin,
        output ready, busy, done, sum, cout
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder; the only arithmetic element in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {cout,sum} = a + b + cin, LSB first,
// one bit per clock through a single full-adder cell.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == LAST_IDX);

    // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
    always_comb begin
        psum_nxt             = psum >> 1;
        psum_nxt[WIDTH-1]    = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: operands captured on acceptance, shifted once per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!bus.abort) begin
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        psum  <= psum_nxt;
                        carry <= fa_co;
                        // Counter holds at the last index so it never wraps.
                        if (last_bit) begin
                            sum_q  <= psum_nxt;
                            cout_q <= fa_co;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances.
module tb_serial_add_ctrl;

    localparam int W8 = 8;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_fail;

    logic [W8-1:0] exp_sum;
    logic          exp_cout;

    serial_add_ctrl_if #(.WIDTH(W8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(1))  if1 ();

    serial_add_ctrl #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W8-1:0] a;
        logic [W8-1:0] b;
        logic          cin;
        logic [W8-1:0] sum;
        logic          cout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 transaction. abort_k selects the RUN cycle (1..W8) that
    // carries abort, 0 means none. Expected result from plain arithmetic.
    task automatic do_op(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic cin,
                         input int abort_k, input bit hold_start, input bit scramble);
        logic [W8:0] full;
        int          waits;
        int          mid_bad;
        waits = 0;
        while (!if8.ready && waits < 20) begin
            tick();
            waits++;
        end
        check("ready_before_start", if8.ready, 1'b1);

        if8.a     = a;
        if8.b     = b;
        if8.cin   = cin;
        if8.abort = 1'b0;
        if8.start = 1'b1;
        tick();
        if (!hold_start) if8.start = 1'b0;
        check("busy_after_accept", if8.busy, 1'b1);

        if (abort_k == 0) begin
            full = {1'b0, a} + {1'b0, b} + {{W8{1'b0}}, cin};
        end else begin
            full = {exp_cout, exp_sum};
        end

        mid_bad = 0;
        for (int e = 1; e <= W8; e++) begin
            if (scramble) begin
                if8.a   = W8'($urandom);
                if8.b   = W8'($urandom);
                if8.cin = 1'($urandom);
            end
            if (e == abort_k) if8.abort = 1'b1;
            tick();
            if8.abort = 1'b0;
            if (e == abort_k) begin
                check("abort_ready", if8.ready, 1'b1);
                check("abort_no_done", if8.done, 1'b0);
                break;
            end
            if (e < W8) begin
                if (if8.done !== 1'b0 || if8.sum !== exp_sum || if8.cout !== exp_cout) mid_bad++;
            end
        end
        check("run_outputs_stable", mid_bad, 0);

        if (abort_k == 0) begin
            // done rises on the (W8+1)th edge counting the accepting edge.
            check("done_latency", if8.done, 1'b1);
            exp_sum  = full[W8-1:0];
            exp_cout = full[W8];
        end
        check("sum", if8.sum, exp_sum);
        check("cout", if8.cout, exp_cout);

        if (abort_k == 0) begin
            tick();
            if8.start = 1'b0;
            check("done_one_cycle", if8.done, 1'b0);
            check("ready_after_done", if8.ready, 1'b1);
        end
        if8.start = 1'b0;
    endtask

    initial begin
        logic [1:0] full1;
        n_cmp    = 0;
        n_fail   = 0;
        exp_sum  = '0;
        exp_cout = 1'b0;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        if8.start = 1'b0; if8.abort = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

        rst_n = 1'b0;
        #2;
        check("rst_ready", if8.ready, 1'b1);
        check("rst_busy", if8.busy, 1'b0);
        check("rst_done", if8.done, 1'b0);
        check("rst_sum", if8.sum, 8'h00);
        check("rst_cout", if8.cout, 1'b0);
        check("rst_ready_w1", if1.ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, 1'b0);
            check("vec_sum", if8.sum, vecs[i].sum);
            check("vec_cout", if8.cout, vecs[i].cout);
        end

        // Start held high, operands scrambled during RUN
        do_op(8'h12, 8'h34, 1'b0, 0, 1'b1, 1'b1);
        check("held_start_sum", if8.sum, 8'h46);
        tick();
        check("held_start_idle", if8.ready, 1'b1);

        // Abort on 4th RUN cycle keeps 8'h46
        do_op(8'h55, 8'h11, 1'b1, 4, 1'b0, 1'b0);
        check("abort_keeps_sum", if8.sum, 8'h46);
        tick();
        check("abort_no_late_done", if8.done, 1'b0);

        // Abort on the last bit edge wins
        do_op(8'h01, 8'h01, 1'b0, W8, 1'b0, 1'b0);
        check("abort_last_sum", if8.sum, 8'h46);

        // Reset mid-RUN
        if8.a = 8'h33; if8.b = 8'h44; if8.cin = 1'b0; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", if8.ready, 1'b1);
        check("midrst_busy", if8.busy, 1'b0);
        check("midrst_done", if8.done, 1'b0);
        check("midrst_sum", if8.sum, 8'h00);
        check("midrst_cout", if8.cout, 1'b0);
        #2;
        rst_n = 1'b1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        tick();
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        check("post_rst_sum", if8.sum, 8'h80);
        check("post_rst_cout", if8.cout, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W8)) : 0;
            do_op(W8'($urandom), W8'($urandom), 1'($urandom), k,
                  1'($urandom_range(0, 1)), 1'b1);
        end

        // WIDTH=1: all operand combinations
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits  = 3'(v);
            full1 = 2'(bits[2]) + 2'(bits[1]) + 2'(bits[0]);
            if1.a   = bits[2];
            if1.b   = bits[1];
            if1.cin = bits[0];
            if1.start = 1'b1;
            tick();
            if1.start = 1'b0;
            if1.a = ~bits[2];
            check("w1_busy", if1.busy, 1'b1);
            tick();
            check("w1_done", if1.done, 1'b1);
            check("w1_sum", if1.sum, full1[0]);
            check("w1_cout", if1.cout, full1[1]);
            tick();
            check("w1_ready", if1.ready, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 1..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin one addition; sampled only when ready=1.
REQ-005 SHALL have port: abort  input  1  cancels an addition in progress.
REQ-006 SHALL have port: a  input  WIDTH  operand A, sampled on the accepting edge.
REQ-007 SHALL have port: b  input  WIDTH  operand B, sampled on the accepting edge.
REQ-008 SHALL have port: cin  input  1  carry-in, sampled on the accepting edge.
REQ-009 SHALL have port: ready  output  1  high in IDLE; start accepted.
REQ-010 SHALL have port: busy  output  1  high in RUN.
REQ-011 SHALL have port: done  output  1  one-cycle pulse in DONE; result valid.
REQ-012 SHALL have port: sum  output  WIDTH  registered result; holds the last completed value.
REQ-013 SHALL have port: cout  output  1  registered carry-out of the last completed addition.

Function
REQ-014 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, through exactly one instance of a 1-bit full-adder cell.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; ready, busy and done SHALL be decoded from state only (Moore).
REQ-016 In IDLE with start=1 at a rising edge, SHALL load shift registers A and B, load carry with cin, clear bit counter, and enter RUN.
REQ-017 In RUN, each edge SHALL shift the cell sum bit into the MSB of the partial-sum register, shift A and B right by one, register the cell carry-out, and increment the counter.
REQ-018 In RUN with counter = WIDTH-1 and abort=0, the edge SHALL copy the completed partial sum to sum and the final carry to cout, and enter DONE.
REQ-019 Latency: done SHALL be high exactly WIDTH+1 edges after the accepting edge; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing, no effect on the operation in flight.
REQ-021 abort=1 in RUN SHALL return the FSM to IDLE on that edge, with no done pulse and sum/cout unchanged; abort SHALL have no effect in IDLE or DONE.
REQ-022 If abort=1 at the counter = WIDTH-1 edge, abort SHALL win: no result update and no done pulse.
REQ-023 Operand changes on a/b/cin after the accepting edge SHALL not affect the result.
REQ-024 The counter SHALL be max(1,clog2(WIDTH)) bits wide and SHALL not wrap within an operation; WIDTH=1 SHALL complete in one RUN cycle.
REQ-025 sum and cout SHALL change only on the RUN-to-DONE edge or on reset.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, and shift registers, carry and counter cleared.
REQ-027 Reset asserted mid-RUN SHALL discard the operation; after release, the next start SHALL behave as from power-up.

Structure
REQ-028 State encoding and the default WIDTH constant SHALL reside in shared package serial_add_pkg.
REQ-029 The 1-bit full adder SHALL be a separate sub-module fa_cell (inputs a, b, ci; outputs s, co), instantiated once.

Verification
REQ-030 WIDTH=8: a=8'h00, b=8'h00, cin=0, start pulse -> done after 9 edges, sum=8'h00, cout=0.
REQ-031 WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
REQ-032 WIDTH=8: start with 8'h12+8'h34, start held high and operands changed during RUN -> exactly one done pulse, sum=8'h46, cout=0.
REQ-033 WIDTH=8: abort on the 4th RUN cycle after a prior result 8'h46 -> no done pulse, ready=1 next cycle, sum stays 8'h46.
REQ-034 rst_n pulsed low mid-RUN -> outputs immediately at reset values; a fresh start computes 8'h7F+8'h01 = 8'h80, cout=0.
REQ-035 WIDTH=1: a=1, b=1, cin=1 -> done 2 edges after acceptance, sum=1, cout=1.
